// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle RV64M multiply/divide sequencer.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle,
// with a valid/ready handshake on both sides and a pipeline flush.
module mdu_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(XLEN) + 1;

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic              is_div, is_rem, is_high, is_word, neg_q, neg_r;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier, divisor, rem;

  logic              mul_w, sign1, sign2, neg1, neg2, div_zero, ovf, fast;
  logic [XLEN-1:0]   ext1, ext2, mag1, mag2, min_n, fast_res;
  logic [2*XLEN-1:0] acc_nxt, prod_f;
  logic [XLEN:0]     rem_sh;
  logic              fits;
  logic [XLEN-1:0]   trial, rem_nxt, q_nxt, quot_f, rem_f, sel, result;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Operand preparation at accept: width extension, magnitudes, fast-case detection
  always_comb begin
    mul_w = word & ~op[2];
    sign1 = ~mul_w & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    sign2 = ~mul_w & (op == 3'b001 || op == 3'b100 || op == 3'b110);
    ext1  = op1;
    ext2  = op2;
    if (word) begin
      ext1 = sign1 ? sext32(op1[31:0]) : {{(XLEN-32){1'b0}}, op1[31:0]};
      ext2 = sign2 ? sext32(op2[31:0]) : {{(XLEN-32){1'b0}}, op2[31:0]};
    end
    neg1  = sign1 & ext1[XLEN-1];
    neg2  = sign2 & ext2[XLEN-1];
    mag1  = neg1 ? -ext1 : ext1;
    mag2  = neg2 ? -ext2 : ext2;
    min_n = '0;
    min_n[XLEN-1] = 1'b1;
    if (word) min_n = {{(XLEN-31){1'b1}}, 31'b0};
    div_zero = (ext2 == '0);
    ovf      = sign1 & sign2 & (ext1 == min_n) & (ext2 == '1);
    fast     = op[2] & (div_zero | ovf);
    fast_res = '0;
    if (div_zero) begin
      if (op[1]) fast_res = word ? sext32(op1[31:0]) : op1;
      else       fast_res = '1;
    end else if (!op[1]) begin
      fast_res = min_n;
    end
  end

  // One iteration step plus the final sign fixup and result selection
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    prod_f  = neg_q ? -acc_nxt : acc_nxt;
    rem_sh  = {rem, mplier[XLEN-1]};
    fits    = (rem_sh >= {1'b0, divisor});
    trial   = rem_sh[XLEN-1:0] - divisor;
    rem_nxt = fits ? trial : rem_sh[XLEN-1:0];
    q_nxt   = {mplier[XLEN-2:0], fits};
    quot_f  = neg_q ? -q_nxt : q_nxt;
    rem_f   = neg_r ? -rem_nxt : rem_nxt;
    if (is_div)       sel = is_rem ? rem_f : quot_f;
    else if (is_high) sel = prod_f[2*XLEN-1:XLEN];
    else              sel = prod_f[XLEN-1:0];
    result = is_word ? sext32(sel[31:0]) : sel;
  end

  // Sequencer state, operand registers and the held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      res     <= '0;
      is_div  <= 1'b0;
      is_rem  <= 1'b0;
      is_high <= 1'b0;
      is_word <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      divisor <= '0;
      rem     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && !flush) begin
          is_div  <= op[2];
          is_rem  <= op[1];
          is_high <= (op != 3'b000) & ~word;
          is_word <= word;
          neg_q   <= neg1 ^ neg2;
          neg_r   <= neg1;
          acc     <= '0;
          mcand   <= {{XLEN{1'b0}}, mag1};
          // word dividends are pre-aligned so the MSB-first shift starts at bit 31
          mplier  <= op[2] ? (word ? (mag1 << 32) : mag1) : mag2;
          divisor <= mag2;
          rem     <= '0;
          if (fast) begin
            res   <= fast_res;
            state <= DONE;
          end else begin
            count <= word ? CW'(32) : CW'(XLEN);
            state <= CALC;
          end
        end
        CALC: if (flush) begin
          state <= IDLE;
        end else begin
          count  <= count - 1'b1;
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= is_div ? q_nxt : (mplier >> 1);
          rem    <= rem_nxt;
          if (count == CW'(1)) begin
            res   <= result;
            state <= DONE;
          end
        end
        DONE: if (flush || out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vector table plus handshake/flush/reset sequences.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  op = 3'b000;
  logic        word = 1'b0;
  logic [63:0] op1 = '0, op2 = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] res;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .op1(op1), .op2(op2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered #1 after a rising edge; returns #1 after the accepting edge (cycle 1).
  task automatic start_op(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
    op = o; word = w; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; word = ~w;
    op1 = 64'hDEAD_BEEF_0BAD_F00D; op2 = 64'h0123_4567_89AB_CDEF;
  endtask

  // Finds the first out_valid cycle, checks latency and result, then takes it.
  task automatic wait_result(input string name, input logic [63:0] exp, input int lat_exp);
    int lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    chk({name, " latency"}, 64'(lat), 64'(lat_exp));
    chk({name, " res"}, res, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " in_ready after take"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] prev;
    logic ok;
    //         op      w     op1                     op2                     expected                lat
    vecs[0]  = '{3'b000, 1'b0, 64'd7,                  -64'd3,                 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{3'b011, 1'b0, '1,                     '1,                     64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{3'b010, 1'b0, '1,                     64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[3]  = '{3'b100, 1'b0, -64'd7,                 64'd2,                  -64'd3,                  65};
    vecs[4]  = '{3'b110, 1'b0, -64'd7,                 64'd2,                  -64'd1,                  65};
    vecs[5]  = '{3'b101, 1'b1, 64'h1_0000_0008,        64'd3,                  64'd2,                   33};
    vecs[6]  = '{3'b100, 1'b0, 64'd5,                  64'd0,                  '1,                      1};
    vecs[7]  = '{3'b110, 1'b0, 64'd5,                  64'd0,                  64'd5,                   1};
    vecs[8]  = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, '1,                    64'h8000_0000_0000_0000, 1};
    vecs[9]  = '{3'b110, 1'b1, 64'h8000_0000,          '1,                     64'd0,                   1};
    vecs[10] = '{3'b001, 1'b0, -64'd5,                 64'd3,                  '1,                      65};
    vecs[11] = '{3'b000, 1'b1, 64'h7FFF_FFFF,          64'd2,                  64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[12] = '{3'b101, 1'b0, 64'd100,                64'd7,                  64'd14,                  65};
    vecs[13] = '{3'b111, 1'b0, 64'd100,                64'd7,                  64'd2,                   65};
    vecs[14] = '{3'b100, 1'b1, 64'h1234_5678_FFFF_FFF8, 64'd3,                 -64'd2,                  33};
    vecs[15] = '{3'b110, 1'b1, 64'h1234_5678_FFFF_FFF8, 64'd3,                 -64'd2,                  33};
    vecs[16] = '{3'b111, 1'b1, 64'hFFFF_FFFF,          64'h10,                 64'd15,                  33};
    vecs[17] = '{3'b101, 1'b1, 64'hFFFF_FFFF,          64'h1_0000_0000,        '1,                      1};
    vecs[18] = '{3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd4,                 64'd2,                   65};
    vecs[19] = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'd2,                 64'hC000_0000_0000_0000, 65};

    // reset values
    #2;
    chk("reset out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset in_ready", {63'b0, in_ready}, 64'd1);
    chk("reset res", res, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b);
      wait_result($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat);
    end

    // busy timeline, in_valid ignored while busy, then a 10-cycle stall in DONE
    start_op(3'b000, 1'b0, 64'd7, -64'd3);
    in_valid = 1'b1; op = 3'b101; op1 = 64'd1; op2 = 64'd1;
    ok = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (!busy || in_ready) ok = 1'b0;
      if (out_valid !== (k == 65)) ok = 1'b0;
    end
    chk("busy cycles 1..65 / out_valid at 65", {63'b0, ok}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!out_valid || in_ready || res !== 64'hFFFF_FFFF_FFFF_FFEB) ok = 1'b0;
    end
    chk("stall holds out_valid/res", {63'b0, ok}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after stall take out_valid", {63'b0, out_valid}, 64'd0);
    chk("after stall take in_ready", {63'b0, in_ready}, 64'd1);

    // flush at count=20 (cycle 45), then a fresh MUL 3*4
    prev = res;
    start_op(3'b000, 1'b0, 64'h55, 64'h66);
    repeat (44) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush calc busy", {63'b0, busy}, 64'd0);
    chk("flush calc out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush calc res kept", res, prev);
    start_op(3'b000, 1'b0, 64'd3, 64'd4);
    wait_result("mul after flush", 64'd12, 65);

    // flush beats out_ready in DONE; flush with in_valid in IDLE is not an accept
    start_op(3'b100, 1'b0, 64'd5, 64'd0);
    @(negedge clk);
    chk("fast done out_valid", {63'b0, out_valid}, 64'd1);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; flush = 1'b0;
    chk("flush done out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush done res kept", res, '1);
    in_valid = 1'b1; flush = 1'b1; op = 3'b000; word = 1'b0; op1 = 64'd2; op2 = 64'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush blocks accept busy", {63'b0, busy}, 64'd0);

    // asynchronous reset mid-CALC
    start_op(3'b001, 1'b0, 64'd9, 64'd9);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", {63'b0, busy}, 64'd0);
    chk("async reset out_valid", {63'b0, out_valid}, 64'd0);
    chk("async reset in_ready", {63'b0, in_ready}, 64'd1);
    chk("async reset res", res, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(3'b111, 1'b0, 64'd17, 64'd5);
    wait_result("remu after reset", 64'd2, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
